// File: rtl/fc_seq_pkg.sv
// rtl/fc_seq_pkg.sv - shared types and sizing/field helpers for fc_layer_sequencer
package fc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2,
        DRAIN  = 2'd3
    } seq_state_t;

    // Width of a counter that must be able to hold the value n.
    function automatic int cnt_w(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // Width of an index selecting one of n items (at least one bit).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Low bit of element idx in a flattened bus of w-bit elements (vec_out, neu_z, z_buf).
    function automatic int field_lsb(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/fc_seq_argmax.sv
// rtl/fc_seq_argmax.sv - running unsigned maximum / index tracker over a drained result stream
module fc_seq_argmax
    import fc_seq_pkg::*;
#(
    parameter int Z_WIDTH = 23,
    parameter int IDX_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               beat,
    input  logic               first,
    input  logic [Z_WIDTH-1:0] data,
    input  logic [IDX_W-1:0]   idx,
    input  logic               last,
    output logic [IDX_W-1:0]   argmax_idx,
    output logic               argmax_valid
);

    logic [Z_WIDTH-1:0] max_q;
    logic [IDX_W-1:0]   max_idx_q;
    logic               take;

    // Strict greater-than keeps the earlier (lower) index on ties.
    assign take = first || (data > max_q);

    // Track the running max per frame and publish the winner after the last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            max_q        <= '0;
            max_idx_q    <= '0;
            argmax_idx   <= '0;
            argmax_valid <= 1'b0;
        end else begin
            argmax_valid <= beat && last;
            if (beat) begin
                if (take) begin
                    max_q     <= data;
                    max_idx_q <= idx;
                end
                if (last) begin
                    argmax_idx <= take ? idx : max_idx_q;
                end
            end
        end
    end

endmodule

// File: rtl/fc_layer_sequencer.sv
// rtl/fc_layer_sequencer.sv - load/settle/drain controller for one FC layer; optional FC_SEQ_ARGMAX_EN
module fc_layer_sequencer
    import fc_seq_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int IN         = 400,
    parameter int N_OUT      = 10,
    parameter int Z_WIDTH    = 23,
    parameter int SETTLE_CYC = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic [WIDTH*IN-1:0]      vec_out,
    input  logic [Z_WIDTH*N_OUT-1:0] neu_z,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [Z_WIDTH-1:0]       out_data,
    output logic [idx_w(N_OUT)-1:0]  out_idx,
    output logic                     out_last,
    output logic                     busy
`ifdef FC_SEQ_ARGMAX_EN
    ,
    output logic [idx_w(N_OUT)-1:0]  argmax_idx,
    output logic                     argmax_valid
`endif
);

    localparam int IN_CW = cnt_w(IN);
    localparam int ST_CW = cnt_w(SETTLE_CYC);
    localparam int IDX_W = idx_w(N_OUT);

    localparam logic [IN_CW-1:0] IN_LAST  = IN_CW'(IN - 1);
    localparam logic [ST_CW-1:0] ST_LAST  = ST_CW'(SETTLE_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_OUT - 1);

    seq_state_t               state;
    logic [IN_CW-1:0]         in_cnt;
    logic [ST_CW-1:0]         settle_cnt;
    logic [Z_WIDTH*N_OUT-1:0] z_buf;
    logic [IDX_W-1:0]         idx_nxt;
    logic                     in_fire;
    logic                     out_fire;

    // Ready is a pure state decode so there is no valid->ready combinational path.
    assign in_ready = (state == IDLE) || (state == LOAD);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign idx_nxt  = out_idx + 1'b1;

    // Frame sequencer: load the vector, hold it while the trees settle, capture, then drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_cnt     <= '0;
            settle_cnt <= '0;
            out_idx    <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
            busy       <= 1'b0;
            vec_out    <= '0;
            z_buf      <= '0;
        end else begin
            case (state)
                IDLE, LOAD: begin
                    // in_cnt is zero in IDLE, so element 0 lands first.
                    if (in_fire) begin
                        vec_out[field_lsb(int'(in_cnt), WIDTH) +: WIDTH] <= in_data;
                        busy <= 1'b1;
                        if (in_cnt == IN_LAST) begin
                            in_cnt     <= '0;
                            settle_cnt <= '0;
                            state      <= SETTLE;
                        end else begin
                            in_cnt <= in_cnt + 1'b1;
                            state  <= LOAD;
                        end
                    end
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt + 1'b1;
                    if (settle_cnt == ST_LAST) begin
                        z_buf     <= neu_z;
                        out_idx   <= '0;
                        out_data  <= neu_z[Z_WIDTH-1:0];
                        out_last  <= (N_OUT == 1);
                        out_valid <= 1'b1;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Without a transfer every output register simply holds.
                    if (out_fire) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            out_idx  <= idx_nxt;
                            out_data <= z_buf[field_lsb(int'(idx_nxt), Z_WIDTH) +: Z_WIDTH];
                            out_last <= (idx_nxt == IDX_LAST);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FC_SEQ_ARGMAX_EN
    fc_seq_argmax #(
        .Z_WIDTH (Z_WIDTH),
        .IDX_W   (IDX_W)
    ) u_argmax (
        .clk          (clk),
        .rst          (rst),
        .beat         (out_fire),
        .first        (out_idx == '0),
        .data         (out_data),
        .idx          (out_idx),
        .last         (out_last),
        .argmax_idx   (argmax_idx),
        .argmax_valid (argmax_valid)
    );
`endif

endmodule
